// File: rtl/reverb_pkg.sv
// Shared reverb delay-line definitions: parameter defaults, tap FSM states and the
// delay length math used identically by the write-side and read-side address generators.
package reverb_pkg;

    localparam int DEF_ADDR_W    = 15;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MIN_DELAY = 4;
    localparam int DELAY_W       = 14;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE
    } tap_state_e;

    // decay_length << octave tops out at 2047*8 = 16376, so 14 bits never overflow.
    function automatic logic [DELAY_W-1:0] delay_len_f(
        input logic [10:0] decay_length,
        input logic [1:0]  octave,
        input int          min_delay = DEF_MIN_DELAY
    );
        logic [DELAY_W-1:0] len;
        len = {3'b000, decay_length} << octave;
        if (len < DELAY_W'(min_delay)) begin
            len = DELAY_W'(min_delay);
        end
        return len;
    endfunction

endpackage

// File: rtl/delay_tap_reader_if.sv
// Bundle of the tap reader's sample-side controls, delay RAM read port and tap output.
// The reader itself is the slave; the surrounding reverb datapath (or a bench) is the master.
interface delay_tap_reader_if
    import reverb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic                     sample_strobe;
    logic [ADDR_W-1:0]        wr_ptr;
    logic [10:0]              decay_length;
    logic [1:0]               octave;
    logic [2:0]               decay_shift;
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [DATA_W-1:0] rd_data;
    logic signed [DATA_W-1:0] q;
    logic                     q_valid;
    logic                     busy;
    logic                     overrun;

    modport master (
        output sample_strobe, wr_ptr, decay_length, octave, decay_shift, rd_data,
        input  rd_en, rd_addr, q, q_valid, busy, overrun
    );

    modport slave (
        input  sample_strobe, wr_ptr, decay_length, octave, decay_shift, rd_data,
        output rd_en, rd_addr, q, q_valid, busy, overrun
    );

endinterface

// File: rtl/delay_addr_calc.sv
// Tap address generator: on each accepted strobe latches (wr_ptr - delay) mod 2^ADDR_W and
// flags taps the writer has not reached yet, using a saturating count of accepted strobes.
module delay_addr_calc
    import reverb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MIN_DELAY = DEF_MIN_DELAY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_wr_ptr,
    input  logic [10:0]       i_decay_length,
    input  logic [1:0]        i_octave,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_warmup
);

    logic [ADDR_W-1:0] w_delay;
    logic [ADDR_W-1:0] r_fill_cnt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_warmup;

    assign w_delay = ADDR_W'(delay_len_f(i_decay_length, i_octave, MIN_DELAY));

    // NOTE: registers use non-blocking assignments and a reset sampled on the clock edge,
    // so every flop here updates together from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fill_cnt <= '0;
            r_rd_addr  <= '0;
            r_warmup   <= 1'b0;
        end else if (i_load) begin
            r_rd_addr <= i_wr_ptr - w_delay;
            r_warmup  <= (r_fill_cnt < w_delay);
            if (r_fill_cnt != '1) begin
                r_fill_cnt <= r_fill_cnt + ADDR_W'(1);
            end
        end
    end

    assign o_rd_addr = r_rd_addr;
    assign o_warmup  = r_warmup;

endmodule

// File: rtl/delay_tap_reader.sv
// Reverb delay-line tap reader: per sample strobe, issues one delay RAM read at wr_ptr - delay,
// waits out the RAM latency and presents the attenuated tap with a one-cycle valid pulse.
module delay_tap_reader
    import reverb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RAM_LAT   = 2,
    parameter int MIN_DELAY = DEF_MIN_DELAY
) (
    input logic                clk,
    input logic                reset,
    delay_tap_reader_if.slave  bus
);

    localparam logic [1:0] WAIT_INIT = 2'(RAM_LAT - 2);

    tap_state_e               r_state;
    tap_state_e               w_next;
    logic [1:0]               r_wait_cnt;
    logic [2:0]               r_shift;
    logic signed [DATA_W-1:0] r_q;
    logic                     r_q_valid;
    logic                     r_overrun;
    logic                     w_rd_en;
    logic                     w_accept;
    logic                     w_drop;
    logic                     w_warmup;
    logic [ADDR_W-1:0]        w_rd_addr;
    logic signed [DATA_W-1:0] w_atten;

    // The cycle carrying q_valid is still the tail of the previous tap, so strobes there drop.
    assign w_accept = bus.sample_strobe && (r_state == IDLE) && !r_q_valid;
    assign w_drop   = bus.sample_strobe && !w_accept;

    delay_addr_calc #(
        .ADDR_W    (ADDR_W),
        .MIN_DELAY (MIN_DELAY)
    ) u_addr_calc (
        .clk            (clk),
        .reset          (reset),
        .i_load         (w_accept),
        .i_wr_ptr       (bus.wr_ptr),
        .i_decay_length (bus.decay_length),
        .i_octave       (bus.octave),
        .o_rd_addr      (w_rd_addr),
        .o_warmup       (w_warmup)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ISSUE) begin
                r_wait_cnt <= WAIT_INIT;
            end else if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt - 2'd1;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        case (r_state)
            IDLE:    if (w_accept) w_next = ISSUE;
            ISSUE: begin
                w_rd_en = 1'b1;
                w_next  = (RAM_LAT > 1) ? WAIT : CAPTURE;
            end
            WAIT:    if (r_wait_cnt == 2'd0) w_next = CAPTURE;
            CAPTURE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Shift kept in its own signed assignment so the mux below cannot turn it into a logical shift.
    assign w_atten = bus.rd_data >>> r_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_q_valid <= (r_state == CAPTURE);
            if (w_accept) begin
                r_shift <= bus.decay_shift;
            end
            if (r_state == CAPTURE) begin
                r_q <= w_warmup ? '0 : w_atten;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.rd_en   = w_rd_en;
    assign bus.rd_addr = w_rd_addr;
    assign bus.q       = r_q;
    assign bus.q_valid = r_q_valid;
    assign bus.busy    = (r_state != IDLE);
    assign bus.overrun = r_overrun;

endmodule
